aes_ctr_sequencer: RTL
======================

Name: aes_ctr_sequencer

Overview:
Sequences the AES encipher datapath to implement CTR-mode encryption and decryption of a 128-bit block stream. It holds the counter block, drives the core's next/block_msg interface, and captures each keystream block. It XORs each keystream block with the input data and presents the result on a valid/ready output. It sits between the AES core's encipher round block and the data-path front end.

Parameters:
CTR_WIDTH, 32, number of LSBs of the counter block that increment; legal range 1..128.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
init  in  1  single-cycle pulse: load iv, abort the current stream
iv  in  128  initial counter block
key_ready  in  1  key expansion complete; launches are allowed only when high
din_valid  in  1  input data valid
din_ready  out  1  input data accepted this cycle
din_data  in  128  plaintext or ciphertext block
dout_valid  out  1  output data valid
dout_ready  in  1  downstream accepts output
dout_data  out  128  din_data XOR keystream
enc_next  out  1  single-cycle start pulse to the encipher block
enc_ready  in  1  encipher block ready/done
enc_block_msg  out  128  block to encipher, always equal to ctr_reg
enc_new_block  in  128  encipher result
ctr_wrap  out  1  sticky flag: the counter field wrapped
busy  out  1  generator FSM not in G_IDLE, or ks_valid, or dout_valid

Behaviour:
Reset values:
- ctr_reg=0, ks_reg=0, ks_valid=0
- dout_valid=0, dout_data=0
- enc_next=0, ctr_wrap=0, busy=0, FSM=G_IDLE

Generator FSM has three states: G_IDLE, G_WAIT, G_DRAIN.
- G_IDLE launch condition: !ks_valid && key_ready && enc_ready && din_valid && !init (din_valid term per Optional Feature).
  - On launch: enc_next=1 for exactly one cycle, go to G_WAIT.
- G_WAIT:
  - enc_ready is ignored in the first cycle after the enc_next pulse (guard cycle).
  - Afterwards, when enc_ready=1: ks_reg<=enc_new_block, ks_valid<=1, counter increments, go to G_IDLE.
- G_DRAIN: entered when init arrives while in G_WAIT.
  - Wait for enc_ready=1 (with the same guard-cycle rule), discard the result, go to G_IDLE.
  - No launch occurs while in G_DRAIN.

Counter:
- enc_block_msg=ctr_reg and is held stable from launch until completion.
- Increment: ctr_reg[CTR_WIDTH-1:0] += 1 modulo 2^CTR_WIDTH; the upper 128-CTR_WIDTH bits are unchanged.
- A wrap from all-ones to zero sets ctr_wrap.

Consume path:
- din_ready = ks_valid && (!dout_valid || dout_ready) && !init.
- On din_valid && din_ready: dout_data<=din_data^ks_reg, dout_valid<=1, ks_valid<=0.
- dout_valid clears on dout_ready unless a new block loads in the same cycle; back-to-back output is allowed.
- dout_data holds stable while dout_valid && !dout_ready.

Latency: if enc_ready rises in cycle T (after the guard cycle), then ks_valid=1 at T+1 and dout_valid=1 at T+2 (given din_valid=1 and the output slot free).

init behaviour:
- ctr_reg<=iv; ks_valid, dout_valid and ctr_wrap are cleared.
- FSM goes to G_IDLE, or to G_DRAIN if it was in G_WAIT.
- init has priority over every other event in the same cycle: a simultaneous din handshake, ks capture or counter increment is suppressed.

key_ready falling mid-operation does not abort the in-flight operation; it only blocks new launches.

Optional Feature:
Macro AES_CTR_PREFETCH_EN.
- Defined: the din_valid term is removed from the launch condition. The next keystream block is generated as soon as ks_valid=0, so din_valid to dout_valid is 1 cycle whenever keystream is ready. After init, one keystream block is generated with no input present.
- Undefined: launch requires din_valid. The counter advances only for blocks that are actually consumed, so no keystream is generated speculatively.

Test Plan:
- AES-128 NIST SP800-38A F.5.1: key 2b7e151628aed2a6abf7158809cf4f3c, init with iv f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff, din 6bc1bee22e409f96e93d7e117393172a then ae2d8a571e03ac9c9eb76fac45af8e51 -> dout 874d6191b620e3261bef6864990db6ce then 9806f66b7970fdff8617187bb9fffdff; ctr_wrap=0.
- Counter wrap, CTR_WIDTH=32: iv low word ffffffff, upper 96 bits all 0xa5 -> second enc_block_msg has low word 00000000 and upper bits unchanged; ctr_wrap=1; a subsequent init clears ctr_wrap.
- Backpressure: hold dout_ready=0 for 20 cycles with a second din pending -> dout_data stable, din_ready=0 throughout, no lost or duplicated block after release.
- init mid-G_WAIT with iv=0 -> enc_next not reasserted until enc_ready returns; the old result is never output; the next launch has enc_block_msg=0.
- key_ready=0 with din_valid=1 -> enc_next stays 0 and busy=0; raising key_ready produces a launch on the next cycle.
- Reset asserted mid-stream -> all outputs return to their reset values asynchronously. With AES_CTR_PREFETCH_EN: after init, ks_valid=1 with no din, and din_valid to dout_valid is 1 cycle.

Source files
------------

// File: rtl/aes_ctr_sequencer.sv
// rtl/aes_ctr_sequencer.sv - CTR-mode sequencer around the AES encipher block.
// Optional AES_CTR_PREFETCH_EN: generate keystream ahead of input data.
module aes_ctr_sequencer #(
  parameter int CTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic [127:0] iv,
  input  logic         key_ready,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic [127:0] din_data,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic [127:0] dout_data,
  output logic         enc_next,
  input  logic         enc_ready,
  output logic [127:0] enc_block_msg,
  input  logic [127:0] enc_new_block,
  output logic         ctr_wrap,
  output logic         busy
);

  typedef enum logic [1:0] {G_IDLE, G_WAIT, G_DRAIN} state_e;

  localparam logic [127:0] CTR_MASK =
    (CTR_WIDTH >= 128) ? {128{1'b1}} : ((128'd1 << CTR_WIDTH) - 128'd1);

  state_e       state_q, state_d;
  logic         enc_next_q, enc_next_d;
  logic         guard_q;
  logic [127:0] ctr_q, ctr_d;
  logic [127:0] ks_q, ks_d;
  logic         ks_valid_q, ks_valid_d;
  logic         dout_valid_q, dout_valid_d;
  logic [127:0] dout_data_q, dout_data_d;
  logic         ctr_wrap_q, ctr_wrap_d;

  logic         launch_req;
  logic         launch;
  logic         enc_done;
  logic         capture;
  logic         din_fire;
  logic [127:0] ctr_inc;

`ifdef AES_CTR_PREFETCH_EN
  assign launch_req = 1'b1;
`else
  assign launch_req = din_valid;
`endif

  assign launch   = (state_q == G_IDLE) && !ks_valid_q && key_ready && enc_ready
                    && launch_req && !init;
  // enc_ready is stale in the pulse cycle and the guard cycle after it
  assign enc_done = enc_ready && !enc_next_q && !guard_q;
  assign capture  = (state_q == G_WAIT) && enc_done && !init;
  assign din_ready = ks_valid_q && (!dout_valid_q || dout_ready) && !init;
  assign din_fire  = din_valid && din_ready;
  assign ctr_inc   = (ctr_q & ~CTR_MASK) | ((ctr_q + 128'd1) & CTR_MASK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= G_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      G_IDLE:  if (launch) state_d = G_WAIT;
      G_WAIT: begin
        if (init)          state_d = G_DRAIN;
        else if (enc_done) state_d = G_IDLE;
      end
      G_DRAIN: if (enc_done) state_d = G_IDLE;
      default: state_d = G_IDLE;
    endcase
  end

  always_comb begin
    enc_next_d   = launch;
    ctr_d        = ctr_q;
    ctr_wrap_d   = ctr_wrap_q;
    ks_d         = ks_q;
    ks_valid_d   = ks_valid_q;
    dout_valid_d = dout_valid_q;
    dout_data_d  = dout_data_q;
    if (init) begin
      ctr_d        = iv;
      ctr_wrap_d   = 1'b0;
      ks_valid_d   = 1'b0;
      dout_valid_d = 1'b0;
    end else begin
      if (capture) begin
        ctr_d      = ctr_inc;
        ks_d       = enc_new_block;
        ks_valid_d = 1'b1;
        if ((ctr_q & CTR_MASK) == CTR_MASK) ctr_wrap_d = 1'b1;
      end
      if (din_fire) begin
        dout_data_d  = din_data ^ ks_q;
        dout_valid_d = 1'b1;
        ks_valid_d   = 1'b0;
      end else if (dout_ready) begin
        dout_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enc_next_q   <= 1'b0;
      guard_q      <= 1'b0;
      ctr_q        <= '0;
      ctr_wrap_q   <= 1'b0;
      ks_q         <= '0;
      ks_valid_q   <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_data_q  <= '0;
    end else begin
      enc_next_q   <= enc_next_d;
      guard_q      <= enc_next_q;
      ctr_q        <= ctr_d;
      ctr_wrap_q   <= ctr_wrap_d;
      ks_q         <= ks_d;
      ks_valid_q   <= ks_valid_d;
      dout_valid_q <= dout_valid_d;
      dout_data_q  <= dout_data_d;
    end
  end

  assign enc_next      = enc_next_q;
  assign enc_block_msg = ctr_q;
  assign dout_valid    = dout_valid_q;
  assign dout_data     = dout_data_q;
  assign ctr_wrap      = ctr_wrap_q;
  assign busy          = (state_q != G_IDLE) || ks_valid_q || dout_valid_q;

endmodule
